pp_accumulator: RTL and testbench

- Sequential partial-product summer for the calculator's 4x4 multiplier path.
- Sits directly downstream of the partial-product AND array and consumes its four WIDTH-bit partial products pp0..pp3 (ppN = a AND b[N]).
- Shift-adds them into a 2*WIDTH-bit product, one partial product per clock.
- Presents the product to the display/result stage with a valid/ready handshake.

---
 rtl/calc_pkg.sv | 38 +++
 rtl/pp_shift_add.sv | 36 +++
 rtl/pp_accumulator.sv | 127 ++++++++++++
 tb/tb_pp_accumulator.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
//
// Shared definitions for the calculator's multiplier datapath.
//
// Contents:
//   DEFAULT_WIDTH - operand width of the 4x4 multiplier path
//   IDX_W         - width of the partial-product index counter
//   state_t       - sequencing states of the partial-product accumulator
//   weighted_pp   - zero-extends a partial product and shifts it into place
// ---------------------------------------------------------------------------
package calc_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Index counter width; a single-bit counter is kept for WIDTH=1
    // so the index never collapses to a zero-width vector.
    localparam int IDX_W = (DEFAULT_WIDTH > 1) ? $clog2(DEFAULT_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Places a WIDTH-bit partial product at its binary weight inside a
    // 2*WIDTH-bit word.  Shifts beyond the word are impossible because
    // shamt never exceeds WIDTH-1.
    function automatic logic [2*DEFAULT_WIDTH-1:0] weighted_pp(
        input logic [DEFAULT_WIDTH-1:0] pp,
        input logic [IDX_W-1:0]         shamt
    );
        logic [2*DEFAULT_WIDTH-1:0] ext;
        ext = {{DEFAULT_WIDTH{1'b0}}, pp};
        return ext << shamt;
    endfunction

endpackage

// File: rtl/pp_shift_add.sv
// ---------------------------------------------------------------------------
// pp_shift_add
//
// Combinational shift-and-add step of the partial-product summer:
//     acc_out = acc_in + (zero-extend(pp) << shamt)
//
// Ports:
//   acc_in  in   2*WIDTH  running sum before this step
//   pp      in   WIDTH    partial product to add
//   shamt   in   SHW      binary weight (shift amount) of pp
//   acc_out out  2*WIDTH  running sum after this step
//
// The sum is never wider than 2*WIDTH bits because the largest possible
// total of all partial products is (2^WIDTH-1)^2, so the carry is dropped.
// ---------------------------------------------------------------------------
module pp_shift_add #(
    parameter int WIDTH = 4,
    parameter int SHW   = 2
) (
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   pp,
    input  logic [SHW-1:0]     shamt,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [2*WIDTH-1:0] pp_ext;
    logic [2*WIDTH-1:0] pp_shifted;

    // Zero-extend first so the shift cannot lose the upper bits of pp.
    always_comb begin
        pp_ext     = {{WIDTH{1'b0}}, pp};
        pp_shifted = pp_ext << shamt;
        acc_out    = acc_in + pp_shifted;
    end

endmodule

// File: rtl/pp_accumulator.sv
// ---------------------------------------------------------------------------
// pp_accumulator
//
// Sequential partial-product summer for the calculator's 4x4 multiplier.
// Accepts the four partial products from the AND array (ppN = a & b[N]),
// adds one per clock at weight 2^N, and presents the 2*WIDTH-bit product
// through a valid/ready handshake.
//
// Ports:
//   clk        in   1        system clock, rising edge
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        pp0..pp3 hold a valid set
//   in_ready   out  1        block can accept a new set (IDLE only)
//   pp0..pp3   in   WIDTH    partial products, weights 2^0..2^3
//   out_valid  out  1        product holds the final result (DONE)
//   out_ready  in   1        downstream accepts the product
//   product    out  2*WIDTH  accumulated product
//   busy       out  1        high in ACCUM or DONE
//
// Timing: a set accepted at edge E0 is summed on edges E0+1..E0+WIDTH and
// out_valid rises after E0+WIDTH.  All outputs are registers or decoded
// from the state register; nothing flows combinationally from inputs.
// ---------------------------------------------------------------------------
module pp_accumulator
    import calc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   pp0,
    input  logic [WIDTH-1:0]   pp1,
    input  logic [WIDTH-1:0]   pp2,
    input  logic [WIDTH-1:0]   pp3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int NUM_PP = 4;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   idx;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_sum;
    logic [2*WIDTH-1:0] product_q;
    logic [WIDTH-1:0]   pp_q [NUM_PP];
    logic [WIDTH-1:0]   pp_sel;

    // The captured copy is what gets summed, so upstream may change
    // pp0..pp3 freely once the set has been accepted.
    always_comb begin
        pp_sel = pp_q[idx];
    end

    pp_shift_add #(
        .WIDTH (WIDTH),
        .SHW   (CNT_W)
    ) u_shift_add (
        .acc_in  (acc),
        .pp      (pp_sel),
        .shamt   (idx),
        .acc_out (acc_sum)
    );

    // Sequencer, index counter and datapath registers.  The product is
    // held in its own register, loaded only by the final add, so partial
    // sums are never visible and IDLE keeps showing the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            product_q <= '0;
            for (int i = 0; i < NUM_PP; i++) begin
                pp_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pp_q[0] <= pp0;
                        pp_q[1] <= pp1;
                        pp_q[2] <= pp2;
                        pp_q[3] <= pp3;
                        acc     <= '0;
                        idx     <= '0;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc_sum;
                    if (idx == LAST_IDX) begin
                        product_q <= acc_sum;
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        idx <= idx + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs are pure state decodes.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == ACCUM) || (state == DONE);
        product   = product_q;
    end

endmodule

// File: tb/tb_pp_accumulator.sv
// ---------------------------------------------------------------------------
// tb_pp_accumulator
//
// Self-checking bench for pp_accumulator.  Expected products come from the
// arithmetic meaning of the partial products (sum of ppN * 2^N); expected
// handshake timing comes from the documented latency.
// ---------------------------------------------------------------------------
module tb_pp_accumulator;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] pp0;
    logic [3:0] pp1;
    logic [3:0] pp2;
    logic [3:0] pp3;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] product;
    logic       busy;

    int compared;
    int mismatched;

    pp_accumulator #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp0       (pp0),
        .pp1       (pp1),
        .pp2       (pp2),
        .pp3       (pp3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the product is the weighted sum of the partial products.
    function automatic int modelProduct(input int a0, input int a1, input int a2, input int a3);
        return a0 * 1 + a1 * 2 + a2 * 4 + a3 * 8;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Runs one transaction starting at a negedge in IDLE and ending at a
    // negedge back in IDLE.  hold = cycles of backpressure in DONE;
    // interfere = scramble pp inputs and pulse in_valid during ACCUM.
    task automatic applyStimulus(input logic [3:0] a0, input logic [3:0] a1,
                                 input logic [3:0] a2, input logic [3:0] a3,
                                 input int hold, input bit interfere);
        int expv;
        expv = modelProduct(int'(a0), int'(a1), int'(a2), int'(a3));

        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        pp0       = a0;
        pp1       = a1;
        pp2       = a2;
        pp3       = a3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;

        // Negedges after E0..E0+3: still accumulating.
        for (int k = 0; k < 4; k++) begin
            checkOutput("accum_out_valid", 32'(out_valid), 32'd0);
            checkOutput("accum_busy", 32'(busy), 32'd1);
            checkOutput("accum_in_ready", 32'(in_ready), 32'd0);
            if (interfere && k < 3) begin
                pp0      = 4'($urandom);
                pp1      = 4'($urandom);
                pp2      = 4'($urandom);
                pp3      = 4'($urandom);
                in_valid = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            if (k == 3) begin
                out_ready = (hold == 0) ? 1'b1 : 1'b0;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end

        // Negedge after E0+4: result presented.
        checkOutput("done_out_valid", 32'(out_valid), 32'd1);
        checkOutput("done_product", 32'(product), 32'(expv));
        checkOutput("done_busy", 32'(busy), 32'd1);
        checkOutput("done_in_ready", 32'(in_ready), 32'd0);

        for (int h = 0; h < hold; h++) begin
            if (h == hold - 1) begin
                in_valid = 1'b1;
            end
            @(negedge clk);
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_product", 32'(product), 32'(expv));
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("post_out_valid", 32'(out_valid), 32'd0);
        checkOutput("post_in_ready", 32'(in_ready), 32'd1);
        checkOutput("post_busy", 32'(busy), 32'd0);
        checkOutput("post_product_kept", 32'(product), 32'(expv));

        // A stray out_ready in IDLE must not disturb anything.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("idle_stray_ready", 32'(out_valid), 32'd0);
        checkOutput("idle_product_kept", 32'(product), 32'(expv));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        pp0        = 4'h0;
        pp1        = 4'h0;
        pp2        = 4'h0;
        pp3        = 4'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_product", 32'(product), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] directed transactions");
        applyStimulus(4'hF, 4'hF, 4'hF, 4'hF, 0, 1'b0);
        checkOutput("ff_literal", 32'(product), 32'hE1);
        applyStimulus(4'hD, 4'hD, 4'h0, 4'hD, 0, 1'b0);
        checkOutput("db_literal", 32'(product), 32'h8F);
        applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 0, 1'b0);
        applyStimulus(4'h9, 4'h0, 4'h9, 4'h9, 10, 1'b0);
        applyStimulus(4'h7, 4'h7, 4'h0, 4'h7, 2, 1'b1);

        // Reset on the second add cycle discards the in-flight result.
        $display("[TB] reset during accumulation");
        pp0      = 4'hA;
        pp1      = 4'h5;
        pp2      = 4'hC;
        pp3      = 4'h3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_product", 32'(product), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 6; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput("midrst_no_stale", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;

        $display("[TB] randomized transactions");
        for (int t = 0; t < 30; t++) begin
            applyStimulus(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
